ring_stop: RTL

- One node of the unidirectional ring interconnect. Sits between a cache agent and the ring.
- Each cycle the incoming ring slot is either ejected to the local agent or forwarded to the next node.
- Local requests are buffered in an injection FIFO. They enter the ring only in free slots; ring traffic always has priority.
- The outgoing ring link is registered, giving a 1-cycle hop latency.

---
 rtl/ring_stop.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ring_stop.sv
// ring_stop: one stop of a unidirectional ring interconnect.
// The incoming slot is either ejected to the local agent, dropped on a bad
// destination, or forwarded. Local messages wait in an injection FIFO and
// use free slots only. The outgoing link is registered (1-cycle hop).
// Optional statistics counters: define RING_STOP_STATS_EN.
module ring_stop #(
  parameter int unsigned NUM_NODES    = 8,
  parameter int unsigned NODE_ID      = 0,
  parameter int unsigned NODE_W       = 3,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned INJ_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              ring_in_valid,
  input  logic [NODE_W-1:0] ring_in_dest,
  input  logic [NODE_W-1:0] ring_in_src,
  input  logic [DATA_W-1:0] ring_in_data,
  output logic              ring_out_valid,
  output logic [NODE_W-1:0] ring_out_dest,
  output logic [NODE_W-1:0] ring_out_src,
  output logic [DATA_W-1:0] ring_out_data,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [NODE_W-1:0] inj_dest,
  input  logic [DATA_W-1:0] inj_data,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic [NODE_W-1:0] ej_src,
  output logic [DATA_W-1:0] ej_data,
  output logic              inj_starved,
  output logic              dest_err
`ifdef RING_STOP_STATS_EN
  ,
  output logic [31:0]       stat_fwd,
  output logic [31:0]       stat_inj,
  output logic [31:0]       stat_ej,
  output logic [31:0]       stat_deflect
`endif
);

  localparam int unsigned PTR_W = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(INJ_DEPTH + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [NODE_W-1:0] NODE_ID_L  = NODE_W'(NODE_ID);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(INJ_DEPTH);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);

  // Injection FIFO storage and state
  logic [NODE_W-1:0] fifo_dest_q [INJ_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [INJ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Registered outputs
  logic              out_valid_q, out_valid_d;
  logic [NODE_W-1:0] out_dest_q, out_dest_d;
  logic [NODE_W-1:0] out_src_q, out_src_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ej_valid_q;
  logic [NODE_W-1:0] ej_src_q;
  logic [DATA_W-1:0] ej_data_q;
  logic              dest_err_q, dest_err_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              starved_q;

  // Slot resolution terms
  logic              in_bad, in_local, ej_free, capture, forward, deflect;
  logic              fifo_empty, push, pop, head_bad, inject;
  logic [NODE_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  // Resolve the incoming slot and decide whether the FIFO head may enter it
  always_comb begin
    in_bad     = ring_in_valid && (32'(ring_in_dest) >= NUM_NODES);
    in_local   = ring_in_valid && !in_bad && (ring_in_dest == NODE_ID_L);
    ej_free    = !ej_valid_q || ej_ready;
    capture    = in_local && ej_free;
    deflect    = in_local && !ej_free;
    forward    = ring_in_valid && !in_bad && !capture;
    fifo_empty = (count_q == '0);
    inj_ready  = (count_q != FULL_CNT);
    push       = inj_valid && inj_ready;
    pop        = !forward && !fifo_empty;
    head_dest  = fifo_dest_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    head_bad   = (32'(head_dest) >= NUM_NODES);
    inject     = pop && !head_bad;
    dest_err_d = in_bad || (pop && head_bad);
  end

  // Next outgoing slot; fields hold their last value when the slot is empty
  always_comb begin
    out_valid_d = forward || inject;
    out_dest_d  = out_dest_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    if (forward) begin
      out_dest_d = ring_in_dest;
      out_src_d  = ring_in_src;
      out_data_d = ring_in_data;
    end else if (inject) begin
      out_dest_d = head_dest;
      out_src_d  = NODE_ID_L;
      out_data_d = head_data;
    end
  end

  // Starvation count: blocked means non-empty FIFO without a pop
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Outgoing ring register and error pulse
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      out_valid_q <= 1'b0;
      out_dest_q  <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      dest_err_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_dest_q  <= out_dest_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      dest_err_q  <= dest_err_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest_q[wr_ptr_q] <= inj_dest;
      fifo_data_q[wr_ptr_q] <= inj_data;
    end
  end

  // Ejection register: capture has priority over drain
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ej_valid_q <= 1'b0;
      ej_src_q   <= '0;
      ej_data_q  <= '0;
    end else if (capture) begin
      ej_valid_q <= 1'b1;
      ej_src_q   <= ring_in_src;
      ej_data_q  <= ring_in_data;
    end else if (ej_ready) begin
      ej_valid_q <= 1'b0;
    end
  end

  // Starvation counter and its flag, aligned to the same edge
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      starve_q  <= '0;
      starved_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      starved_q <= (starve_d == STARVE_MAX);
    end
  end

  assign ring_out_valid = out_valid_q;
  assign ring_out_dest  = out_dest_q;
  assign ring_out_src   = out_src_q;
  assign ring_out_data  = out_data_q;
  assign ej_valid       = ej_valid_q;
  assign ej_src         = ej_src_q;
  assign ej_data        = ej_data_q;
  assign inj_starved    = starved_q;
  assign dest_err       = dest_err_q;

`ifdef RING_STOP_STATS_EN
  logic [31:0] fwd_q, inj_q, ej_q, defl_q;

  // Event counters, wrapping modulo 2**32
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      fwd_q  <= '0;
      inj_q  <= '0;
      ej_q   <= '0;
      defl_q <= '0;
    end else begin
      if (forward) fwd_q  <= fwd_q + 32'd1;
      if (inject)  inj_q  <= inj_q + 32'd1;
      if (capture) ej_q   <= ej_q + 32'd1;
      if (deflect) defl_q <= defl_q + 32'd1;
    end
  end

  assign stat_fwd     = fwd_q;
  assign stat_inj     = inj_q;
  assign stat_ej      = ej_q;
  assign stat_deflect = defl_q;
`endif

endmodule
